// File: rtl/ring_counter_checker.sv
// Receiving-end monitor for a one-hot ring counter: decodes, locks onto clean rotation, counts errors and laps.
// Optional idle watchdog enabled by defining RING_COUNTER_CHECKER_TIMEOUT_EN.
module ring_counter_checker #(
    parameter int WIDTH    = 4,
    parameter int ROT_LEFT = 1,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8,
    parameter int LAP_W    = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         q_in,
    input  logic                     q_valid,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     onehot_ok,
    output logic                     locked,
    output logic                     seq_err,
    output logic                     wrap_pulse,
    output logic [ERR_W-1:0]         err_count,
    output logic [LAP_W-1:0]         lap_count,
    output logic                     timeout
);
    localparam int IW = $clog2(WIDTH);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] PRED = (ROT_LEFT != 0) ? (ONE << (WIDTH - 1)) : (ONE << 1);

    typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [GW-1:0]    good_cnt;

    logic             legal;
    logic             match;
    logic             wrap_hit;
    logic [IW-1:0]    dec_idx;
    logic [WIDTH-1:0] expected;

    always_comb begin
        legal    = ($countones(q_in) == 1);
        expected = (ROT_LEFT != 0) ? {prev[WIDTH-2:0], prev[WIDTH-1]}
                                   : {prev[0], prev[WIDTH-1:1]};
        match    = legal && (q_in == expected);
        wrap_hit = (q_in == ONE) && (prev == PRED);
        dec_idx  = '0;
        for (int i = 0; i < WIDTH; i++)
            if (q_in[i]) dec_idx = IW'(i);
    end

`ifdef RING_COUNTER_CHECKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            prev       <= '0;
            good_cnt   <= '0;
            index      <= '0;
            onehot_ok  <= 1'b0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            lap_count  <= '0;
`ifdef RING_COUNTER_CHECKER_TIMEOUT_EN
            timeout    <= 1'b0;
            idle_cnt   <= '0;
`endif
        end else begin
            seq_err    <= 1'b0;
            wrap_pulse <= 1'b0;
`ifdef RING_COUNTER_CHECKER_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            if (q_valid) begin
                prev      <= q_in;
                onehot_ok <= legal;
                if (legal) index <= dec_idx;
`ifdef RING_COUNTER_CHECKER_TIMEOUT_EN
                idle_cnt  <= '0;
`endif
                case (state)
                    SEARCH: begin
                        if (legal) begin
                            good_cnt <= '0;
                            state    <= LOCKING;
                        end
                    end
                    LOCKING: begin
                        if (!legal) begin
                            good_cnt <= '0;
                            state    <= SEARCH;
                        end else if (match) begin
                            good_cnt <= good_cnt + 1'b1;
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            // Legal but off-sequence: restart the lock run from this sample
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            if (wrap_hit) begin
                                wrap_pulse <= 1'b1;
                                lap_count  <= lap_count + 1'b1;
                            end
                        end else begin
                            seq_err  <= 1'b1;
                            if (err_count != '1) err_count <= err_count + 1'b1;
                            state    <= SEARCH;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                endcase
            end
`ifdef RING_COUNTER_CHECKER_TIMEOUT_EN
            // Idle watchdog only runs once a sequence has been acquired
            else if (state != SEARCH) begin
                if (idle_cnt == TW'(TIMEOUT - 1)) begin
                    timeout  <= 1'b1;
                    state    <= SEARCH;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_ring_counter_checker.sv
// Self-checking bench for ring_counter_checker: directed vector table, corner sequences, random vs. model.
module tb_ring_counter_checker;
    localparam int LOCK_CNT = 2;
    localparam int TIMEOUT  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] q_in = 4'b0001;
    logic       q_valid = 1'b1;
    logic [1:0] index;
    logic       onehot_ok, locked, seq_err, wrap_pulse, timeout;
    logic [7:0] err_count, lap_count;

    int total = 0;
    int bad = 0;

    ring_counter_checker #(
        .WIDTH(4), .ROT_LEFT(1), .LOCK_CNT(LOCK_CNT), .ERR_W(8), .LAP_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .q_valid(q_valid), .index(index),
        .onehot_ok(onehot_ok), .locked(locked), .seq_err(seq_err), .wrap_pulse(wrap_pulse),
        .err_count(err_count), .lap_count(lap_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, v;
        logic [3:0] q;
        logic       lk, se, wp, ok;
        logic [1:0] ix;
        logic [7:0] ec, lc;
    } vec_t;
    vec_t tbl[$];

    // Reference model: length of the current chain of correct rotations decides lock state
    int         m_chain, m_idle;
    logic [3:0] m_prev;
    logic [1:0] m_idx;
    logic       m_ok, m_seq, m_wrap, m_to;
    logic [7:0] m_err, m_lap;

    function automatic logic [3:0] rot(input logic [3:0] x);
        return 4'(((x << 1) | (x >> 3)) & 4'hF);
    endfunction

    function automatic int ones(input logic [3:0] x);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(x[i]);
        return n;
    endfunction

    task automatic model(input logic rst, input logic v, input logic [3:0] q);
        bit was_locked, lg, ext;
        if (rst) begin
            m_chain = 0; m_idle = 0; m_prev = 0; m_idx = 0; m_ok = 0;
            m_seq = 0; m_wrap = 0; m_to = 0; m_err = 0; m_lap = 0;
            return;
        end
        m_seq = 0; m_wrap = 0; m_to = 0;
        was_locked = (m_chain >= LOCK_CNT + 1);
        if (v) begin
            lg  = (ones(q) == 1);
            ext = lg && m_chain > 0 && q == rot(m_prev);
            if (was_locked) begin
                if (ext) begin
                    m_wrap = (q == 4'd1);
                    if (m_wrap) m_lap = m_lap + 8'd1;
                end else begin
                    m_seq = 1;
                    if (m_err != 8'd255) m_err = m_err + 8'd1;
                    m_chain = 0;
                end
            end else begin
                m_chain = !lg ? 0 : ext ? m_chain + 1 : 1;
            end
            m_ok = lg;
            if (lg) m_idx = 2'($clog2(q));
            m_prev = q;
            m_idle = 0;
        end
`ifdef RING_COUNTER_CHECKER_TIMEOUT_EN
        else if (m_chain > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_to = 1; m_chain = 0; m_idle = 0;
            end
        end
`endif
    endtask

    task automatic step(input logic rst, input logic v, input logic [3:0] q);
        reset = rst; q_valid = v; q_in = q;
        @(posedge clk);
        #1;
        model(rst, v, q);
        chk("locked",    locked,     m_chain >= LOCK_CNT + 1);
        chk("seq_err",   seq_err,    m_seq);
        chk("wrap",      wrap_pulse, m_wrap);
        chk("onehot_ok", onehot_ok,  m_ok);
        chk("index",     index,      m_idx);
        chk("err_count", err_count,  m_err);
        chk("lap_count", lap_count,  m_lap);
        chk("timeout",   timeout,    m_to);
    endtask

    initial begin
        logic [3:0] last_q;
        int r;

        //            rst v  q        lk se wp ok ix ec lc
        tbl.push_back('{1, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 4'b0001, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 4'b0010, 0, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 4'b0100, 1, 0, 0, 1, 2, 0, 0});
        tbl.push_back('{0, 1, 4'b1000, 1, 0, 0, 1, 3, 0, 0});
        tbl.push_back('{0, 1, 4'b0001, 1, 0, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 4'b0010, 1, 0, 0, 1, 1, 0, 1});
        tbl.push_back('{0, 1, 4'b0000, 0, 1, 0, 0, 1, 1, 1});
        tbl.push_back('{0, 0, 4'b1111, 0, 0, 0, 0, 1, 1, 1});
        tbl.push_back('{0, 1, 4'b0001, 0, 0, 0, 1, 0, 1, 1});
        tbl.push_back('{0, 1, 4'b0010, 0, 0, 0, 1, 1, 1, 1});
        tbl.push_back('{0, 1, 4'b0100, 1, 0, 0, 1, 2, 1, 1});
        tbl.push_back('{0, 1, 4'b1000, 1, 0, 0, 1, 3, 1, 1});
        tbl.push_back('{0, 1, 4'b0001, 1, 0, 1, 1, 0, 1, 2});
        tbl.push_back('{0, 1, 4'b0100, 0, 1, 0, 1, 2, 2, 2});
        tbl.push_back('{0, 1, 4'b0100, 0, 0, 0, 1, 2, 2, 2});
        tbl.push_back('{0, 1, 4'b1000, 0, 0, 0, 1, 3, 2, 2});
        tbl.push_back('{0, 1, 4'b0001, 1, 0, 0, 1, 0, 2, 2});
        tbl.push_back('{0, 1, 4'b1100, 0, 1, 0, 0, 0, 3, 2});
        tbl.push_back('{0, 1, 4'b1100, 0, 0, 0, 0, 0, 3, 2});
        tbl.push_back('{1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 4'b0001, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 4'b0010, 0, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 4'b0100, 1, 0, 0, 1, 2, 0, 0});
        tbl.push_back('{0, 1, 4'b0010, 0, 1, 0, 1, 1, 1, 0});
        tbl.push_back('{0, 1, 4'b0010, 0, 0, 0, 1, 1, 1, 0});
        tbl.push_back('{0, 1, 4'b0010, 0, 0, 0, 1, 1, 1, 0});
        tbl.push_back('{0, 1, 4'b0100, 0, 0, 0, 1, 2, 1, 0});
        tbl.push_back('{0, 1, 4'b1000, 1, 0, 0, 1, 3, 1, 0});
        tbl.push_back('{0, 1, 4'b1000, 0, 1, 0, 1, 3, 2, 0});

        foreach (tbl[i]) begin
            reset = tbl[i].rst; q_valid = tbl[i].v; q_in = tbl[i].q;
            @(posedge clk);
            #1;
            chk("t_locked",  locked,     tbl[i].lk);
            chk("t_seq_err", seq_err,    tbl[i].se);
            chk("t_wrap",    wrap_pulse, tbl[i].wp);
            chk("t_ok",      onehot_ok,  tbl[i].ok);
            chk("t_index",   index,      tbl[i].ix);
            chk("t_err",     err_count,  tbl[i].ec);
            chk("t_lap",     lap_count,  tbl[i].lc);
            chk("t_timeout", timeout,    1'b0);
        end

        // Error counter saturation over 300 lock/error rounds
        step(1, 0, 4'b0000);
        for (int k = 0; k < 300; k++) begin
            step(0, 1, 4'b0001);
            step(0, 1, 4'b0010);
            step(0, 1, 4'b0100);
            step(0, 1, 4'b0000);
        end
        chk("err_sat", err_count, 8'd255);
        step(0, 1, 4'b1100);
        chk("search_no_err", seq_err, 1'b0);

        // Idle watchdog
        step(1, 0, 4'b0000);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0100);
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 4'b0000);
`ifdef RING_COUNTER_CHECKER_TIMEOUT_EN
            if (k == 15) chk("to_pre", {timeout, locked}, 2'b01);
            if (k == 16) chk("to_fire", {timeout, locked}, 2'b10);
            if (k == 17) chk("to_once", timeout, 1'b0);
`else
            if (k == 20) chk("no_to", {timeout, locked}, 2'b01);
`endif
        end
        chk("to_err_kept", err_count, 8'd0);

        // Random traffic against the model
        last_q = 4'b0001;
        step(1, 0, 4'b0000);
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] q;
            r = int'($urandom_range(0, 99));
            if (r < 65)      q = rot(last_q);
            else if (r < 80) q = 4'(1 << $urandom_range(0, 3));
            else if (r < 90) q = 4'($urandom_range(0, 15));
            else             q = last_q;
            last_q = q;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ring_counter_checker.md
Name: ring_counter_checker

Overview:
- Receiving-end monitor for the one-hot ring counter sequence. Samples a WIDTH-bit ring pattern, decodes it to a binary index and checks that it is legal one-hot.
- Verifies single-step rotation, locks onto a clean sequence, and counts errors and completed laps.
- Sits beside any ring counter instance as a synthesizable self-check and diagnostic block.

Parameters:
- WIDTH, 4, ring length in bits; minimum 2.
- ROT_LEFT, 1, expected rotation. 1: next = {q[WIDTH-2:0], q[WIDTH-1]}, i.e. 0001->0010. 0: rotate right.
- LOCK_CNT, 2, consecutive correct advances required to enter LOCKED; minimum 1.
- ERR_W, 8, width of err_count (saturating).
- LAP_W, 8, width of lap_count (wrapping).
- TIMEOUT, 16, idle cycles for the watchdog; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- q_in  input  WIDTH  ring pattern under test
- q_valid  input  1  q_in sampled only on cycles where this is high
- index  output  clog2(WIDTH)  binary position of the set bit of the last legal sample
- onehot_ok  output  1  last sample had exactly one bit set
- locked  output  1  high in LOCKED state
- seq_err  output  1  one-cycle pulse on a detected error
- wrap_pulse  output  1  one-cycle pulse when a locked sequence returns to bit 0
- err_count  output  ERR_W  saturating count of seq_err pulses
- lap_count  output  LAP_W  wrapping count of wrap_pulse events
- timeout  output  1  one-cycle watchdog pulse; constant 0 without the optional feature

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; port names are clk and reset.
- Reset values: index=0, onehot_ok=0, locked=0, seq_err=0, wrap_pulse=0, err_count=0, lap_count=0, timeout=0, state=SEARCH, prev=0, good_cnt=0. Reset overrides q_valid in the same cycle.
- Latency: all outputs are registered and reflect a sample one cycle after the q_valid edge. With q_valid low, state and outputs hold; pulses return to 0.
- Legal sample: exactly one bit set. Illegal sample: all-zero or more than one bit set.
  - Legal sample: index = position of the set bit.
  - Illegal sample: index holds its previous value and onehot_ok=0.
- expected = prev rotated per ROT_LEFT. prev updates to q_in on every valid sample, legal or not.
- State machine:
  - SEARCH: a legal sample loads prev and sets good_cnt=0, then moves to LOCKING. An illegal sample stays in SEARCH with no seq_err.
  - LOCKING: sample == expected increments good_cnt; when good_cnt reaches LOCK_CNT, move to LOCKED. A legal sample != expected reloads prev, clears good_cnt and stays in LOCKING. An illegal sample returns to SEARCH. No seq_err is raised in LOCKING.
  - LOCKED: sample == expected stays in LOCKED. Any other sample (illegal, skipped step, repeated value, wrong direction) pulses seq_err, increments err_count and moves to SEARCH.
- wrap_pulse: fires in LOCKED when the accepted sample == 1 (bit 0 set) and prev == bit WIDTH-1 for ROT_LEFT=1, or prev == bit 1 for ROT_LEFT=0. lap_count increments on the same cycle and wraps from 2^LAP_W-1 to 0.
- err_count saturates at 2^ERR_W-1 and never wraps.
- An error and a wrap on the same sample cannot coincide: an error sample is never accepted, so wrap_pulse stays 0.
- Reset mid-operation: a cleanly stepping sequence needs LOCK_CNT+1 valid samples after reset deassertion before locked rises.

Optional Feature:
- Macro: RING_COUNTER_CHECKER_TIMEOUT_EN.
- Defined:
  - An idle counter runs only while in LOCKING or LOCKED. It clears on each q_valid cycle and increments on each cycle without q_valid.
  - On reaching TIMEOUT: pulse timeout for one cycle, go to SEARCH, clear good_cnt and the idle counter. err_count is not incremented.
- Undefined: no idle counter is built, timeout is tied to 0, and states never leave LOCKING/LOCKED because of idle time.

Test Plan:
- Reset with q_valid=1, q_in=0001 held for 3 cycles -> all outputs 0, state SEARCH; on the first edge after release, onehot_ok=1, index=0.
- Continuous valid, ROT_LEFT=1: 0001,0010,0100,1000,0001 -> locked=1 one cycle after 0100 (LOCK_CNT=2); wrap_pulse=1 and lap_count=1 one cycle after the second 0001; seq_err never asserted.
- Locked at 0010, then inject 0000 -> one cycle later seq_err=1, err_count=1, locked=0, onehot_ok=0, index stays 1.
- Locked at 0001, then inject 0100 (skip) -> seq_err=1, err_count=1, SEARCH; 0100,1000,0001 then re-locks with err_count still 1.
- Force 300 lock/error cycles with ERR_W=8 -> err_count stops at 255; 1100 arriving in SEARCH produces no seq_err.
- With RING_COUNTER_CHECKER_TIMEOUT_EN, TIMEOUT=16: lock, then hold q_valid=0 -> timeout pulse on idle cycle 16, locked=0, err_count unchanged. Without the macro: the same stimulus leaves locked=1 and timeout=0.
